// File: rtl/instrumented_adder_sequencer_if.sv
// Bus between the measurement sequencer and the instrumented ripple adder.
// The sequencer drives operands and run-enable, and the adder returns its completion flag and sum.
interface instrumented_adder_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             adder_run;
    logic             chain_out;
    logic [WIDTH:0]   sum_in;

    modport master (
        output adder_a,
        output adder_b,
        output adder_run,
        input  chain_out,
        input  sum_in
    );

    modport slave (
        input  adder_a,
        input  adder_b,
        input  adder_run,
        output chain_out,
        output sum_in
    );
endinterface

// File: rtl/instrumented_adder_sequencer.sv
// Runs the instrumented adder N times, timing how long chain_out takes to rise in each run.
// Results accumulate across runs and are held for LA readback.
module instrumented_adder_sequencer #(
    parameter int               WIDTH   = 32,
    parameter int               CNT_W   = 24,
    parameter int               SETTLE  = 4,
    parameter logic [CNT_W-1:0] TIMEOUT = {CNT_W{1'b1}}
) (
    input  logic                                 wb_clk_i,
    input  logic                                 wb_rst_i,
    input  logic                                 start,
    input  logic [WIDTH-1:0]                     a_cfg,
    input  logic [WIDTH-1:0]                     b_cfg,
    input  logic [7:0]                           n_runs,
    instrumented_adder_sequencer_if.master       adder,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 timeout,
    output logic                                 stuck,
    output logic [7:0]                           run_idx,
    output logic [CNT_W-1:0]                     last_count,
    output logic [CNT_W-1:0]                     max_count,
    output logic [CNT_W+7:0]                     total_count,
    output logic [WIDTH:0]                       sum_out
);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_MEASURE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic             start_q;
    logic             cs_meta;
    logic             cs;
    logic             start_edge;
    logic             settle_last;
    logic [SW-1:0]    settle_cnt;
    logic [CNT_W-1:0] counter;
    logic [7:0]       runs_lat;
    logic [7:0]       run_idx_next;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic             run_en;
    logic             launch;
    logic             stuck_hit;
    logic             timeout_hit;

    assign start_edge   = start & ~start_q;
    assign settle_last  = (settle_cnt == SW'(SETTLE - 1));
    assign run_idx_next = run_idx + 8'd1;

    assign adder.adder_a   = a_lat;
    assign adder.adder_b   = b_lat;
    assign adder.adder_run = run_en;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        stuck_hit   = 1'b0;
        timeout_hit = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        run_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    launch  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                // A chain already complete with run low means the adder cannot be timed.
                if (settle_last) begin
                    if (cs) begin
                        stuck_hit = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_MEASURE;
                    end
                end
            end
            S_MEASURE: begin
                busy   = 1'b1;
                run_en = 1'b1;
                if (cs) begin
                    state_d = S_CAPTURE;
                end else if (counter == TIMEOUT) begin
                    timeout_hit = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_CAPTURE: begin
                busy    = 1'b1;
                state_d = (run_idx_next == runs_lat) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done = 1'b1;
                if (start_edge) begin
                    launch  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: chain_out synchronizer, run timing and result accumulation.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            start_q     <= 1'b0;
            cs_meta     <= 1'b0;
            cs          <= 1'b0;
            settle_cnt  <= '0;
            counter     <= '0;
            runs_lat    <= '0;
            a_lat       <= '0;
            b_lat       <= '0;
            run_idx     <= '0;
            last_count  <= '0;
            max_count   <= '0;
            total_count <= '0;
            sum_out     <= '0;
            timeout     <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            start_q <= start;
            cs_meta <= adder.chain_out;
            cs      <= cs_meta;

            if (launch) begin
                a_lat       <= a_cfg;
                b_lat       <= b_cfg;
                runs_lat    <= (n_runs == 8'd0) ? 8'd1 : n_runs;
                run_idx     <= '0;
                last_count  <= '0;
                max_count   <= '0;
                total_count <= '0;
                sum_out     <= '0;
                timeout     <= 1'b0;
                stuck       <= 1'b0;
            end

            if (state_q == S_LOAD) begin
                settle_cnt <= '0;
            end

            if (state_q == S_SETTLE) begin
                settle_cnt <= settle_cnt + SW'(1);
                counter    <= '0;
            end

            if (state_q == S_MEASURE && !cs && counter < TIMEOUT) begin
                counter <= counter + CNT_W'(1);
            end

            if (stuck_hit) begin
                stuck <= 1'b1;
            end

            if (timeout_hit) begin
                timeout <= 1'b1;
            end

            if (state_q == S_CAPTURE) begin
                last_count  <= counter;
                total_count <= total_count + {8'd0, counter};
                if (counter > max_count) begin
                    max_count <= counter;
                end
                sum_out <= adder.sum_in;
                run_idx <= run_idx_next;
            end
        end
    end
endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Bench for instrumented_adder_sequencer: a behavioural adder plus a run-schedule model of the expected outputs.
// Directed sequences are checked every cycle against the model and pinned with hand-computed literals.
module tb_instrumented_adder_sequencer;
    localparam int               WIDTH   = 32;
    localparam int               CNT_W   = 24;
    localparam int               SETTLE  = 4;
    localparam logic [CNT_W-1:0] TIMEOUT = 24'd10;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i = 1'b1;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  a_cfg = '0;
    logic [WIDTH-1:0]  b_cfg = '0;
    logic [7:0]        n_runs = '0;
    logic              busy, done, timeout, stuck;
    logic [7:0]        run_idx;
    logic [CNT_W-1:0]  last_count, max_count;
    logic [CNT_W+7:0]  total_count;
    logic [WIDTH:0]    sum_out;

    instrumented_adder_sequencer_if #(.WIDTH(WIDTH)) adder_bus ();

    instrumented_adder_sequencer #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start),
        .a_cfg(a_cfg), .b_cfg(b_cfg), .n_runs(n_runs), .adder(adder_bus.master),
        .busy(busy), .done(done), .timeout(timeout), .stuck(stuck),
        .run_idx(run_idx), .last_count(last_count), .max_count(max_count),
        .total_count(total_count), .sum_out(sum_out)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int e0_cyc = 0;
    bit check_en = 0;

    // Plan for the next sequence: per-run edge at which chain_out is first sampled high (0 = never).
    int plan_k[$];
    bit plan_stuck = 0;
    bit force_high = 0;

    bit               m_seq = 0;
    int               m_t = 0;
    int               m_runs = 0;
    int               m_k[$];
    bit               m_stuck = 0;
    bit               prev_start = 0;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;

    typedef struct {
        bit               busy, done, run, to, st;
        int               idx;
        longint           last, maxc, total;
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] a, b;
    } exp_t;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Each run is LOAD, SETTLE cycles, count+1 measuring cycles, CAPTURE; results appear after CAPTURE.
    function automatic exp_t model_expect();
        exp_t e;
        int base, u, c;
        e = '{default: 0};
        if (!m_seq) return e;
        e.a = m_a;
        e.b = m_b;
        base = 0;
        for (int r = 0; r < m_runs; r++) begin
            u = m_t - base;
            if (m_stuck) begin
                if (u <= SETTLE) e.busy = 1; else begin e.done = 1; e.st = 1; end
                return e;
            end
            if (m_k[r] == 0) begin
                if (u <= SETTLE + int'(TIMEOUT) + 1) begin
                    e.busy = 1;
                    e.run  = (u > SETTLE);
                end else begin
                    e.done = 1;
                    e.to   = 1;
                end
                return e;
            end
            c = m_k[r] + 1;
            if (u < SETTLE + c + 3) begin
                e.busy = 1;
                e.run  = (u > SETTLE && u <= SETTLE + c + 1);
                return e;
            end
            e.idx   = r + 1;
            e.last  = c;
            e.total = e.total + c;
            if (c > e.maxc) e.maxc = c;
            e.sum   = {1'b0, m_a} + {1'b0, m_b};
            base    = base + SETTLE + c + 3;
        end
        e.done = 1;
        return e;
    endfunction

    always @(posedge wb_clk_i) cyc++;

    always @(posedge wb_clk_i) begin
        exp_t cur;
        if (wb_rst_i) begin
            m_seq      = 0;
            prev_start = 0;
        end else begin
            cur = model_expect();
            if (start && !prev_start && (!m_seq || cur.done)) begin
                m_seq   = 1;
                m_t     = 0;
                m_a     = a_cfg;
                m_b     = b_cfg;
                m_runs  = (n_runs == 8'd0) ? 1 : int'(n_runs);
                m_k     = plan_k;
                m_stuck = plan_stuck;
            end else if (m_seq) begin
                m_t++;
            end
            prev_start = start;
        end
    end

    // Behavioural adder: completes k edges after run rises, drops chain_out when run falls.
    int run_age = 0;
    int runs_seen = 0;
    always @(negedge wb_clk_i) begin
        int k;
        if (!m_seq || m_t == 0) runs_seen = 0;
        if (adder_bus.adder_run === 1'b1) begin
            if (run_age == 0) runs_seen++;
            run_age++;
        end else begin
            run_age = 0;
        end
        k = (runs_seen > 0 && runs_seen <= m_k.size()) ? m_k[runs_seen-1] : 0;
        adder_bus.chain_out = force_high || (adder_bus.adder_run === 1'b1 && k != 0 && run_age >= k);
    end
    assign adder_bus.sum_in = {1'b0, adder_bus.adder_a} + {1'b0, adder_bus.adder_b};

    always @(negedge wb_clk_i) begin
        exp_t e;
        if (check_en) begin
            e = model_expect();
            checkOutput("cyc_busy", busy, e.busy);
            checkOutput("cyc_done", done, e.done);
            checkOutput("cyc_run", adder_bus.adder_run, e.run);
            checkOutput("cyc_timeout", timeout, e.to);
            checkOutput("cyc_stuck", stuck, e.st);
            checkOutput("cyc_run_idx", run_idx, e.idx);
            checkOutput("cyc_last", last_count, e.last);
            checkOutput("cyc_max", max_count, e.maxc);
            checkOutput("cyc_total", total_count, e.total);
            checkOutput("cyc_sum", sum_out, e.sum);
            checkOutput("cyc_adder_a", adder_bus.adder_a, e.a);
            checkOutput("cyc_adder_b", adder_bus.adder_b, e.b);
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [7:0] n, input bit hold);
        @(posedge wb_clk_i);
        #1;
        a_cfg  = a;
        b_cfg  = b;
        n_runs = n;
        start  = 1'b1;
        @(posedge wb_clk_i);
        #1;
        e0_cyc = cyc;
        if (!hold) start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int n);
        @(negedge wb_clk_i);
        while (done !== 1'b1 && (cyc - e0_cyc) < budget) @(negedge wb_clk_i);
        n = cyc - e0_cyc;
        checkOutput("done_reached", done, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        adder_bus.chain_out = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        check_en = 1;
        @(negedge wb_clk_i);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_run_idx", run_idx, 0);
        #1 wb_rst_i = 1'b0;

        $display("[TB] single run, chain high at first edge, start held high");
        plan_k = '{1};
        applyStimulus(32'd5, 32'd7, 8'd1, 1'b1);
        waitDone(300, n);
        checkOutput("t1_done_edge", n, 9);
        checkOutput("t1_last", last_count, 2);
        checkOutput("t1_max", max_count, 2);
        checkOutput("t1_total", total_count, 2);
        checkOutput("t1_sum", sum_out, 12);
        checkOutput("t1_run_idx", run_idx, 1);
        repeat (3) @(negedge wb_clk_i);
        checkOutput("t1_no_retrigger", done, 1);
        start = 1'b0;

        $display("[TB] three runs k=3,5,1 with a start pulse while busy");
        plan_k = '{3, 5, 1};
        applyStimulus(32'hFFFF_FFFF, 32'd1, 8'd3, 1'b0);
        repeat (10) @(posedge wb_clk_i);
        #1 start = 1'b1;
        @(posedge wb_clk_i);
        #1 start = 1'b0;
        waitDone(300, n);
        checkOutput("t2_done_edge", n, 33);
        checkOutput("t2_total", total_count, 12);
        checkOutput("t2_max", max_count, 6);
        checkOutput("t2_last", last_count, 2);
        checkOutput("t2_run_idx", run_idx, 3);
        checkOutput("t2_sum", sum_out, 33'h1_0000_0000);

        $display("[TB] timeout with chain held low");
        plan_k = '{0};
        applyStimulus(32'd3, 32'd4, 8'd1, 1'b0);
        waitDone(300, n);
        checkOutput("t3_done_edge", n, SETTLE + 12);
        checkOutput("t3_timeout", timeout, 1);
        checkOutput("t3_run_idx", run_idx, 0);
        checkOutput("t3_total", total_count, 0);
        checkOutput("t3_run_low", adder_bus.adder_run, 0);

        $display("[TB] chain stuck high before start");
        @(posedge wb_clk_i);
        #1 force_high = 1;
        repeat (3) @(posedge wb_clk_i);
        plan_k = '{0, 0};
        plan_stuck = 1;
        applyStimulus(32'd9, 32'd9, 8'd2, 1'b0);
        waitDone(300, n);
        checkOutput("t4_done_edge", n, SETTLE + 1);
        checkOutput("t4_stuck", stuck, 1);
        checkOutput("t4_run_idx", run_idx, 0);
        #1 force_high = 0;
        plan_stuck = 0;
        repeat (3) @(posedge wb_clk_i);

        $display("[TB] reset during measurement, then n_runs=0 run");
        plan_k = '{8, 8};
        applyStimulus(32'd50, 32'd60, 8'd2, 1'b0);
        repeat (7) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_run", adder_bus.adder_run, 0);
        checkOutput("t5_rst_adder_a", adder_bus.adder_a, 0);
        plan_k = '{2};
        applyStimulus(32'd100, 32'd23, 8'd0, 1'b0);
        waitDone(300, n);
        checkOutput("t5_done_edge", n, 10);
        checkOutput("t5_run_idx", run_idx, 1);
        checkOutput("t5_last", last_count, 3);
        checkOutput("t5_sum", sum_out, 123);

        $display("[TB] restart from DONE clears results");
        plan_k = '{4, 2};
        applyStimulus(32'h1234, 32'h4321, 8'd2, 1'b0);
        @(negedge wb_clk_i);
        checkOutput("t6_cleared_idx", run_idx, 0);
        checkOutput("t6_cleared_total", total_count, 0);
        checkOutput("t6_busy", busy, 1);
        waitDone(300, n);
        checkOutput("t6_done_edge", n, 22);
        checkOutput("t6_total", total_count, 8);
        checkOutput("t6_max", max_count, 5);
        checkOutput("t6_last", last_count, 3);
        checkOutput("t6_sum", sum_out, 33'h5555);

        $display("[TB] start edge coincident with reset");
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b1;
        start    = 1'b1;
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        checkOutput("t7_busy", busy, 0);
        checkOutput("t7_done", done, 0);

        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instrumented_adder_sequencer.md
# instrumented_adder_sequencer

Measurement sequencer directly upstream of the instrumented ripple adder. It latches operands and run count from the logic-analyser config, then drives the adder's operand and run-enable inputs. Each run it times, in `wb_clk_i` cycles, how long the adder takes to raise `chain_out`, and captures the sum. Results are accumulated over N runs and held for LA readback.

## Interface
Parameters:
- `WIDTH`, 32, adder operand width
- `CNT_W`, 24, per-run cycle counter width
- `SETTLE`, 4, idle cycles with run low before each measurement (≥3)
- `TIMEOUT`, 24'hFFFFFF, maximum per-run count before abort (≤ 2^CNT_W−1)

Ports:
- `wb_clk_i` in 1: sole clock
- `wb_rst_i` in 1: synchronous, active-high reset
- `start` in 1: level from LA; a rising edge launches a sequence
- `a_cfg`, `b_cfg` in WIDTH: operands, latched on the start edge
- `n_runs` in 8: run count, latched on the start edge; 0 is treated as 1
- `adder_a`, `adder_b` out WIDTH: latched operands to the adder
- `adder_run` out 1: adder chain enable
- `chain_out` in 1: adder completion, asynchronous to the clock
- `sum_in` in WIDTH+1: adder sum plus carry
- `busy`, `done`, `timeout`, `stuck` out 1: status
- `run_idx` out 8: number of completed runs
- `last_count`, `max_count` out CNT_W; `total_count` out CNT_W+8
- `sum_out` out WIDTH+1: sum captured in the last completed run

## Operation
- `chain_out` passes through a 2-flop synchronizer (`cs`). Both flops are cleared by reset.
- Start edge = `start & ~start_q`. It is ignored unless the state is IDLE or DONE.
- States:
  - IDLE → LOAD on start edge. The same edge latches operands and `n_runs`, and clears `run_idx`, all counts, `sum_out`, `timeout`, `stuck` and `done`.
  - LOAD, 1 cycle: `adder_run=0`. → SETTLE.
  - SETTLE, SETTLE cycles: `adder_run=0`. On the last cycle, if `cs=1`, set `stuck` and go to DONE; otherwise go to MEASURE with the counter cleared.
  - MEASURE: `adder_run=1`.
    - Each cycle with `cs=0` and counter < TIMEOUT: counter +1.
    - `cs=1`: → CAPTURE.
    - `cs=0` and counter == TIMEOUT: set `timeout`, → DONE. That run is not accumulated.
  - CAPTURE, 1 cycle: `adder_run=0`. Actions: `last_count`=counter, `total_count`+=counter, `max_count`=max(`max_count`, counter), `sum_out`=`sum_in`, `run_idx`+1. If the new `run_idx` equals the latched runs, go to DONE; otherwise go to LOAD.
  - DONE: `done=1`, `adder_run=0`, all results held. A start edge → LOAD with the same clearing as from IDLE.
- `busy` = 1 in LOAD, SETTLE, MEASURE and CAPTURE.
- `total_count` cannot overflow (at most 255 × (2^CNT_W−1)).
- `adder_a`/`adder_b` stay constant from the start edge through DONE.

## Timing
- Reset: all outputs, the state (IDLE), the synchronizer and `start_q` are 0 one edge after `wb_rst_i` is sampled high. Reset mid-sequence aborts immediately with `adder_run=0`, and results are lost.
- Start edge at clock edge E0 gives LOAD after E0, SETTLE after E1, and MEASURE after E(SETTLE+1).
- If `chain_out` is first sampled high at the k-th edge after MEASURE entry (k≥1), count = k+1 because of the 2-cycle sync latency. If `chain_out` is held high throughout, count = 2.
- Per-run period = SETTLE + count + 3 cycles.
- `done` rises after edge E(runs × (SETTLE+count+3)).
- Timeout run: `timeout` and `done` rise together, TIMEOUT+1 cycles after MEASURE entry.
- A start edge coincident with reset is ignored. `start` held high does not retrigger.

## Test plan
- Single run, `a_cfg`=5, `b_cfg`=7, `n_runs`=1, `chain_out` held high, `sum_in`=12 → `done` at E9 (SETTLE=4). Outputs: `last_count`=`max_count`=`total_count`=2, `sum_out`=12, `run_idx`=1, `timeout`=`stuck`=0.
- `n_runs`=3 with `chain_out` first sampled high at k=3, 5, 1 in successive runs → counts 4, 6, 2. Outputs: `total_count`=12, `max_count`=6, `last_count`=2, `run_idx`=3.
- TIMEOUT=10, `chain_out` held low → `timeout`=1 and `done`=1. Outputs: `run_idx`=0, `total_count`=0; `adder_run` falls the same cycle.
- `chain_out` held high before start → `stuck`=1 and `done` after SETTLE cycles; `adder_run` never asserts.
- Start edge while busy is ignored. `wb_rst_i` pulsed during MEASURE → all outputs 0 next cycle and state IDLE. A fresh start then runs normally.
- `n_runs`=0 behaves as 1. A second start edge from DONE clears the previous results before the new sequence runs.
